random_gen: RTL

Parametrised Galois-LFSR pseudo-random source with a programmable sample divider, runtime reseeding and a valid/ready output. It is the general-purpose successor of the fixed 10-bit LED randomiser, and serves LED demos, dither, test-pattern generators and other fabric consumers that need a throttled random word.

---
 rtl/random_gen_if.sv | 11 +
 rtl/random_gen.sv | 77 +++++++
 2 files changed

// File: rtl/random_gen_if.sv
// Valid/ready stream carrying the throttled random word from random_gen to its consumer.
interface random_gen_if #(
    parameter int OUT_W = 4
);
    logic [OUT_W-1:0] rnd;
    logic             rnd_valid;
    logic             rnd_ready;

    modport master (output rnd, output rnd_valid, input rnd_ready);
    modport slave  (input rnd, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/random_gen.sv
// Galois-LFSR random source with an enable-gated sample divider, runtime reseed and a
// valid/ready output word; a word arriving while the previous one is unaccepted is dropped.
module random_gen #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(16'hB400),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int               OUT_W = 4,
    parameter int               DIV   = 16777216
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
    random_gen_if.master     rnd_bus,
    output logic             overrun
);
    localparam int            CW      = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] s_next;
    logic [CW-1:0]    cnt_reg;
    logic [OUT_W-1:0] rnd_reg;
    logic             valid_reg;
    logic             overrun_reg;
    logic             tick;

    // One Galois right-shift step: bit i takes bit i+1, XORed with the tap when the LSB is set.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_step
            if (gi == WIDTH - 1) begin : g_top
                assign s_next[gi] = TAPS[gi] & s_reg[0];
            end else begin : g_mid
                assign s_next[gi] = s_reg[gi + 1] ^ (TAPS[gi] & s_reg[0]);
            end
        end
    endgenerate

    assign tick = en && !seed_load && (cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_reg       <= SEED;
            cnt_reg     <= '0;
            rnd_reg     <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (seed_load) begin
            // A zero seed would lock the LFSR, so it is replaced by SEED.
            s_reg       <= (seed_in != '0) ? seed_in : SEED;
            cnt_reg     <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            if (en) begin
                s_reg   <= s_next;
                cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
            end
            if (tick) begin
                if (!valid_reg || rnd_bus.rnd_ready) begin
                    rnd_reg   <= s_reg[OUT_W-1:0];
                    valid_reg <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (valid_reg && rnd_bus.rnd_ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign rnd_bus.rnd       = rnd_reg;
    assign rnd_bus.rnd_valid = valid_reg;
    assign overrun           = overrun_reg;
endmodule
